// File: rtl/inst_sram_axi_rd_bridge.sv
// Instruction-fetch SRAM-like read port to AXI4 read-only master (AR + R), single fixed ARID.
// Latency: req->addr_ok 0 cycles, addr_ok->arvalid 1 cycle, R handshake->data_ok 0 cycles (+1 with INST_BRIDGE_RDATA_REG_EN).
// Backpressure: addr_ok withheld while an AR is pending or MAX_OUT reads are outstanding; rready only while reads are outstanding.
module inst_sram_axi_rd_bridge #(
  parameter logic [3:0] ARID    = 4'd0,
  parameter int         MAX_OUT = 2,
  parameter int         CNT_W   = 3
) (
  input  logic        clk,
  input  logic        resetn,
  // fetch-side SRAM-like read port
  input  logic        inst_sram_req,
  input  logic        inst_sram_wr,
  input  logic [1:0]  inst_sram_size,
  input  logic [31:0] inst_sram_addr,
  output logic        inst_sram_addr_ok,
  output logic        inst_sram_data_ok,
  output logic [31:0] inst_sram_rdata,
  // AXI AR channel
  output logic [3:0]  arid,
  output logic [31:0] araddr,
  output logic [7:0]  arlen,
  output logic [2:0]  arsize,
  output logic [1:0]  arburst,
  output logic [1:0]  arlock,
  output logic [3:0]  arcache,
  output logic [2:0]  arprot,
  output logic        arvalid,
  input  logic        arready,
  // AXI R channel
  input  logic [3:0]  rid,
  input  logic [31:0] rdata,
  input  logic [1:0]  rresp,
  input  logic        rlast,
  input  logic        rvalid,
  output logic        rready
);

  typedef enum logic [0:0] {
    AR_IDLE = 1'b0,
    AR_SEND = 1'b1
  } ar_state_t;

  localparam logic [CNT_W-1:0] MAX_OUT_C = CNT_W'(MAX_OUT);

  ar_state_t        state;
  ar_state_t        state_nxt;
  logic [31:0]      araddr_q;
  logic [1:0]       size_q;
  logic [CNT_W-1:0] out_cnt;
  logic [CNT_W-1:0] out_cnt_nxt;
  logic             rready_q;
  logic             r_hs;
  logic             cnt_room;
  logic             acc;

  // Single fixed ID and single-beat INCR reads only; rid/rlast carry no information here.
  assign arid    = ARID;
  assign arlen   = 8'd0;
  assign arburst = 2'b01;
  assign arlock  = 2'b00;
  assign arcache = 4'b0000;
  assign arprot  = 3'b000;
  assign araddr  = araddr_q;
  assign arsize  = {1'b0, size_q};

  logic unused_ok;
  assign unused_ok = &{1'b0, rid, rresp, rlast};

  assign r_hs = rvalid & rready;

  // A return in the same cycle frees a slot, so a full bridge can accept on that cycle.
  assign cnt_room = (out_cnt < MAX_OUT_C) | r_hs;
  assign acc      = inst_sram_addr_ok;

  // AR FSM next state and combinational outputs.
  always_comb begin
    state_nxt         = state;
    inst_sram_addr_ok = 1'b0;
    arvalid           = 1'b0;
    case (state)
      AR_IDLE: begin
        inst_sram_addr_ok = inst_sram_req & ~inst_sram_wr & cnt_room;
        if (inst_sram_addr_ok) begin
          state_nxt = AR_SEND;
        end
      end
      AR_SEND: begin
        arvalid = 1'b1;
        if (arready) begin
          state_nxt = AR_IDLE;
        end
      end
      default: begin
        state_nxt = AR_IDLE;
      end
    endcase
  end

  // AR FSM state register.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state <= AR_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Capture address/size on accept; held stable through AR_SEND until the handshake.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      araddr_q <= 32'd0;
      size_q   <= 2'd0;
    end else if (acc) begin
      araddr_q <= inst_sram_addr;
      size_q   <= inst_sram_size;
    end
  end

  // Outstanding count: +1 on accept, -1 on R handshake, unchanged when both coincide.
  always_comb begin
    out_cnt_nxt = out_cnt;
    case ({acc, r_hs})
      2'b10:   out_cnt_nxt = out_cnt + CNT_W'(1);
      2'b01:   out_cnt_nxt = out_cnt - CNT_W'(1);
      default: out_cnt_nxt = out_cnt;
    endcase
  end

  // Count register plus rready registered from the next count, so rready tracks out_cnt != 0.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      out_cnt  <= '0;
      rready_q <= 1'b0;
    end else begin
      out_cnt  <= out_cnt_nxt;
      rready_q <= (out_cnt_nxt != '0);
    end
  end

`ifdef INST_BRIDGE_RDATA_REG_EN
  logic        data_ok_q;
  logic [31:0] rdata_q;

  // The fetch side consumes data_ok unconditionally, so the output register drains
  // every cycle and never needs to hold off rready.
  assign rready            = rready_q;
  assign inst_sram_data_ok = data_ok_q;
  assign inst_sram_rdata   = rdata_q;

  // Register the R beat to break the rvalid -> data_ok path.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      data_ok_q <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      data_ok_q <= r_hs;
      if (r_hs) begin
        rdata_q <= rdata;
      end
    end
  end
`else
  assign rready            = rready_q;
  assign inst_sram_data_ok = r_hs;
  assign inst_sram_rdata   = rdata;
`endif

endmodule

// File: tb/tb_inst_sram_axi_rd_bridge.sv
module tb_inst_sram_axi_rd_bridge;

  logic        clk;
  logic        resetn;
  logic        inst_sram_req;
  logic        inst_sram_wr;
  logic [1:0]  inst_sram_size;
  logic [31:0] inst_sram_addr;
  logic        inst_sram_addr_ok;
  logic        inst_sram_data_ok;
  logic [31:0] inst_sram_rdata;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  int errors = 0;
  int checks = 0;
  int dok_pulses = 0;
  int base;

  inst_sram_axi_rd_bridge dut (
    .clk               (clk),
    .resetn            (resetn),
    .inst_sram_req     (inst_sram_req),
    .inst_sram_wr      (inst_sram_wr),
    .inst_sram_size    (inst_sram_size),
    .inst_sram_addr    (inst_sram_addr),
    .inst_sram_addr_ok (inst_sram_addr_ok),
    .inst_sram_data_ok (inst_sram_data_ok),
    .inst_sram_rdata   (inst_sram_rdata),
    .arid              (arid),
    .araddr            (araddr),
    .arlen             (arlen),
    .arsize            (arsize),
    .arburst           (arburst),
    .arlock            (arlock),
    .arcache           (arcache),
    .arprot            (arprot),
    .arvalid           (arvalid),
    .arready           (arready),
    .rid               (rid),
    .rdata             (rdata),
    .rresp             (rresp),
    .rlast             (rlast),
    .rvalid            (rvalid),
    .rready            (rready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] rd;
    logic        exp_acc;
    logic [2:0]  exp_arsize;
  } vec_t;

  vec_t vecs [5];

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Count data_ok pulses and flag any R beat accepted with nothing outstanding.
  always @(posedge clk) begin
    if (inst_sram_data_ok) dok_pulses++;
    if (resetn && rvalid && rready && dut.out_cnt == 3'd0) begin
      errors++;
      $display("FAIL r_beat_no_outstanding: got out_cnt 0 expected nonzero");
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0] = '{1'b0, 32'hbfc00000, 2'd2, 32'h3c1d0000, 1'b1, 3'b010};
    vecs[1] = '{1'b0, 32'h00001002, 2'd1, 32'h0000beef, 1'b1, 3'b001};
    vecs[2] = '{1'b0, 32'h00000003, 2'd0, 32'h000000a5, 1'b1, 3'b000};
    vecs[3] = '{1'b1, 32'h00000010, 2'd2, 32'h12345678, 1'b0, 3'b010};
    vecs[4] = '{1'b0, 32'hfffffffc, 2'd2, 32'hdeadbeef, 1'b1, 3'b010};

    resetn = 1'b0;
    inst_sram_req = 1'b0; inst_sram_wr = 1'b0; inst_sram_size = 2'd0; inst_sram_addr = 32'd0;
    arready = 1'b0; rid = 4'd0; rdata = 32'd0; rresp = 2'd0; rlast = 1'b0; rvalid = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_arvalid", arvalid, 0);
    check("rst_rready", rready, 0);
    check("rst_out_cnt", dut.out_cnt, 0);
    check("rst_state", 32'(dut.state), 0);
    check("rst_addr_ok", inst_sram_addr_ok, 0);
    check("rst_data_ok", inst_sram_data_ok, 0);
    check("rst_rdata", inst_sram_rdata, 0);
    check("rst_araddr", araddr, 0);
    check("rst_arsize", arsize, 0);
    resetn = 1'b1;

    // Single reads from the vector table
    for (int i = 0; i < 5; i++) begin
      tick();
      inst_sram_req = 1'b1; inst_sram_wr = vecs[i].wr;
      inst_sram_addr = vecs[i].addr; inst_sram_size = vecs[i].size;
      #1;
      check($sformatf("v%0d_addr_ok", i), inst_sram_addr_ok, vecs[i].exp_acc);
      if (!vecs[i].exp_acc) begin
        tick();
        #1;
        check($sformatf("v%0d_wr_addr_ok", i), inst_sram_addr_ok, 0);
        check($sformatf("v%0d_wr_arvalid", i), arvalid, 0);
        check($sformatf("v%0d_wr_out_cnt", i), dut.out_cnt, 0);
        inst_sram_req = 1'b0; inst_sram_wr = 1'b0;
      end else begin
        tick();
        inst_sram_req = 1'b0;
        #1;
        check($sformatf("v%0d_arvalid", i), arvalid, 1);
        check($sformatf("v%0d_araddr", i), araddr, vecs[i].addr);
        check($sformatf("v%0d_arsize", i), arsize, vecs[i].exp_arsize);
        check($sformatf("v%0d_arlen", i), arlen, 0);
        check($sformatf("v%0d_arburst", i), arburst, 1);
        check($sformatf("v%0d_arid", i), arid, 0);
        check($sformatf("v%0d_out_cnt1", i), dut.out_cnt, 1);
        check($sformatf("v%0d_rready1", i), rready, 1);
        arready = 1'b1;
        tick();
        arready = 1'b0;
        #1;
        check($sformatf("v%0d_arvalid_done", i), arvalid, 0);
        tick();
        rvalid = 1'b1; rdata = vecs[i].rd;
        #1;
        check($sformatf("v%0d_data_ok", i), inst_sram_data_ok, 1);
        check($sformatf("v%0d_rdata", i), inst_sram_rdata, vecs[i].rd);
        tick();
        rvalid = 1'b0; rdata = 32'd0;
        #1;
        check($sformatf("v%0d_data_ok_low", i), inst_sram_data_ok, 0);
        check($sformatf("v%0d_out_cnt0", i), dut.out_cnt, 0);
        check($sformatf("v%0d_rready0", i), rready, 0);
      end
    end

    // Outstanding limit, then ordering of returns
    tick();
    arready = 1'b1; inst_sram_req = 1'b1; inst_sram_addr = 32'hbfc00000; inst_sram_size = 2'd2;
    #1;
    check("lim_acc0", inst_sram_addr_ok, 1);
    tick();
    inst_sram_addr = 32'hbfc00004;
    #1;
    check("lim_send0_addr_ok", inst_sram_addr_ok, 0);
    check("lim_send0_arvalid", arvalid, 1);
    tick();
    #1;
    check("lim_acc1", inst_sram_addr_ok, 1);
    tick();
    inst_sram_addr = 32'hbfc00008;
    #1;
    check("lim_send1_addr_ok", inst_sram_addr_ok, 0);
    check("lim_out_cnt2", dut.out_cnt, 2);
    tick();
    #1;
    check("lim_stall0", inst_sram_addr_ok, 0);
    check("lim_stall_state", 32'(dut.state), 0);
    check("lim_stall_arvalid", arvalid, 0);
    tick();
    #1;
    check("lim_stall1", inst_sram_addr_ok, 0);
    tick();
    rvalid = 1'b1; rdata = 32'h3c1d0000;
    #1;
    check("lim_acc2_on_return", inst_sram_addr_ok, 1);
    check("lim_ret0_data_ok", inst_sram_data_ok, 1);
    check("lim_ret0_rdata", inst_sram_rdata, 32'h3c1d0000);
    tick();
    base = dok_pulses;
    inst_sram_req = 1'b0; rdata = 32'h11111111;
    #1;
    check("ord_out_cnt_held", dut.out_cnt, 2);
    check("ord_araddr", araddr, 32'hbfc00008);
    check("ord_ret1_data_ok", inst_sram_data_ok, 1);
    check("ord_ret1_rdata", inst_sram_rdata, 32'h11111111);
    tick();
    rdata = 32'h22222222;
    #1;
    check("ord_out_cnt1", dut.out_cnt, 1);
    check("ord_ret2_data_ok", inst_sram_data_ok, 1);
    check("ord_ret2_rdata", inst_sram_rdata, 32'h22222222);
    tick();
    rvalid = 1'b0; rdata = 32'd0; arready = 1'b0;
    #1;
    check("ord_out_cnt0", dut.out_cnt, 0);
    check("ord_rready0", rready, 0);
    tick();
    #1;
    check("ord_pulses", dok_pulses - base, 2);

    // AR backpressure: arready low for 5 cycles
    tick();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h00000100; inst_sram_size = 2'd2;
    #1;
    check("bp_acc0", inst_sram_addr_ok, 1);
    tick();
    inst_sram_addr = 32'h00000104;
    #1;
    check("bp_arvalid_c0", arvalid, 1);
    check("bp_araddr_c0", araddr, 32'h00000100);
    check("bp_addr_ok_c0", inst_sram_addr_ok, 0);
    for (int c = 1; c < 5; c++) begin
      tick();
      #1;
      check($sformatf("bp_arvalid_c%0d", c), arvalid, 1);
      check($sformatf("bp_araddr_c%0d", c), araddr, 32'h00000100);
      check($sformatf("bp_addr_ok_c%0d", c), inst_sram_addr_ok, 0);
    end
    tick();
    arready = 1'b1;
    #1;
    check("bp_hs_arvalid", arvalid, 1);
    check("bp_hs_addr_ok", inst_sram_addr_ok, 0);
    tick();
    arready = 1'b0;
    #1;
    check("bp_idle_state", 32'(dut.state), 0);
    check("bp_idle_arvalid", arvalid, 0);
    check("bp_acc1", inst_sram_addr_ok, 1);
    tick();
    inst_sram_req = 1'b0;
    #1;
    check("bp_araddr1", araddr, 32'h00000104);
    check("bp_out_cnt2", dut.out_cnt, 2);
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'haaaa0001;
    #1;
    check("bp_ret0", inst_sram_rdata, 32'haaaa0001);
    tick();
    rdata = 32'haaaa0002;
    #1;
    check("bp_ret1", inst_sram_rdata, 32'haaaa0002);
    tick();
    rvalid = 1'b0; rdata = 32'd0;
    #1;
    check("bp_out_cnt0", dut.out_cnt, 0);

    // Simultaneous accept and return with one outstanding
    tick();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h00000200;
    #1;
    check("sim_acc0", inst_sram_addr_ok, 1);
    tick();
    inst_sram_req = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0;
    #1;
    check("sim_out_cnt1", dut.out_cnt, 1);
    tick();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h00000204; rvalid = 1'b1; rdata = 32'h55aa55aa;
    #1;
    check("sim_addr_ok", inst_sram_addr_ok, 1);
    check("sim_data_ok", inst_sram_data_ok, 1);
    tick();
    inst_sram_req = 1'b0; rvalid = 1'b0; rdata = 32'd0;
    #1;
    check("sim_out_cnt_held", dut.out_cnt, 1);
    check("sim_rready_held", rready, 1);
    check("sim_araddr", araddr, 32'h00000204);
    arready = 1'b1;
    tick();
    arready = 1'b0; rvalid = 1'b1; rdata = 32'h66666666;
    #1;
    check("sim_ret1", inst_sram_rdata, 32'h66666666);
    tick();
    rvalid = 1'b0; rdata = 32'd0;
    #1;
    check("sim_out_cnt0", dut.out_cnt, 0);

    // Async reset while in AR_SEND with two outstanding
    tick();
    inst_sram_req = 1'b1; inst_sram_addr = 32'h00000300;
    tick();
    inst_sram_req = 1'b0; arready = 1'b1;
    tick();
    arready = 1'b0; inst_sram_req = 1'b1; inst_sram_addr = 32'h00000304;
    #1;
    check("ar_acc1", inst_sram_addr_ok, 1);
    tick();
    inst_sram_req = 1'b0;
    #1;
    check("ar_pre_state", 32'(dut.state), 1);
    check("ar_pre_out_cnt", dut.out_cnt, 2);
    #2;
    resetn = 1'b0;
    #1;
    check("ar_arvalid", arvalid, 0);
    check("ar_rready", rready, 0);
    check("ar_out_cnt", dut.out_cnt, 0);
    check("ar_state", 32'(dut.state), 0);
    tick();
    resetn = 1'b1;
    tick();
    #1;
    check("ar_post_arvalid", arvalid, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
